// File: rtl/wb_slave_pkg.sv
// Shared types and constants for the Wishbone register-file responder.
package wb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_slv_state_t;

  localparam int WS_CNT_WIDTH = 4;

endpackage

// File: rtl/wb_wait_cnt.sv
// Loadable wait-state down-counter; zero flag is registered alongside the count.
module wb_wait_cnt
  import wb_slave_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load,
  input  logic                    en,
  input  logic [WS_CNT_WIDTH-1:0] load_val,
  output logic                    zero
);

  localparam logic [WS_CNT_WIDTH-1:0] CNT_ZERO = {WS_CNT_WIDTH{1'b0}};
  localparam logic [WS_CNT_WIDTH-1:0] CNT_ONE  = {{(WS_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WS_CNT_WIDTH-1:0] cnt_r;
  logic                    zero_r;

  // count register; zero flag predicts the value after the update
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r  <= CNT_ZERO;
      zero_r <= 1'b1;
    end else if (load) begin
      cnt_r  <= load_val;
      zero_r <= (load_val == CNT_ZERO);
    end else if (en) begin
      cnt_r  <= cnt_r - CNT_ONE;
      zero_r <= (cnt_r == CNT_ONE);
    end else begin
      cnt_r  <= cnt_r;
      zero_r <= zero_r;
    end
  end

  assign zero = zero_r;

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic-cycle responder backed by a small register file, with
// programmable wait states and a level interrupt from one register's bit 0.
module wb_slave_regfile
  import wb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1,
  parameter int IRQ_ADDR    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o
);

  localparam int REG_COUNT = 2 ** ADDR_WIDTH;
  localparam logic [WS_CNT_WIDTH-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WS_CNT_WIDTH'(WAIT_STATES - 1) : {WS_CNT_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] IRQ_IDX = ADDR_WIDTH'(IRQ_ADDR);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("wb_slave_regfile: WAIT_STATES must be in 0..15");
  end
  if (IRQ_ADDR < 0 || IRQ_ADDR >= REG_COUNT) begin : g_bad_irq_addr
    $error("wb_slave_regfile: IRQ_ADDR outside the register file");
  end

  wb_slv_state_t state_r, state_nxt_s;

  logic                  req_s;
  logic                  capture_s;
  logic                  commit_s;
  logic                  cnt_load_s;
  logic                  cnt_en_s;
  logic                  cnt_zero_s;
  logic                  we_cap_r;
  logic [ADDR_WIDTH-1:0] adr_cap_r;
  logic [DATA_WIDTH-1:0] dat_cap_r;
  logic [ADDR_WIDTH-1:0] rd_adr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  ack_r;
  logic                  irq_r;

  assign req_s = cyc_i & stb_i;

  wb_wait_cnt u_wait_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (cnt_load_s),
    .en       (cnt_en_s),
    .load_val (WS_LOAD),
    .zero     (cnt_zero_s)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state, counter control, capture and commit strobes
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    commit_s    = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          capture_s   = 1'b1;
          cnt_load_s  = 1'b1;
          state_nxt_s = (WAIT_STATES == 0) ? ACK : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else if (cnt_zero_s) begin
          state_nxt_s = ACK;
        end else begin
          cnt_en_s    = 1'b1;
          state_nxt_s = WAIT;
        end
      end
      ACK: begin
        // a request dropped during ACK still ends the ack but loses the write
        commit_s    = req_s;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // request capture on acceptance in IDLE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_cap_r  <= 1'b0;
      adr_cap_r <= {ADDR_WIDTH{1'b0}};
      dat_cap_r <= DATA_ZERO;
    end else if (capture_s) begin
      we_cap_r  <= we_i;
      adr_cap_r <= adr_i;
      dat_cap_r <= dat_i;
    end else begin
      we_cap_r  <= we_cap_r;
      adr_cap_r <= adr_cap_r;
      dat_cap_r <= dat_cap_r;
    end
  end

  // with zero wait states ACK is entered from IDLE, before the capture lands
  always_comb begin
    rd_adr_s  = adr_cap_r;
    if (state_r == IDLE) begin
      rd_adr_s = adr_i;
    end else begin
      rd_adr_s = adr_cap_r;
    end
    rd_data_s = regs_r[rd_adr_s];
  end

  // register file write and interrupt level, updated on the same commit edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
      irq_r <= 1'b0;
    end else if (commit_s && we_cap_r) begin
      regs_r[adr_cap_r] <= dat_cap_r;
      if (adr_cap_r == IRQ_IDX) begin
        irq_r <= dat_cap_r[0];
      end else begin
        irq_r <= irq_r;
      end
    end else begin
      irq_r <= irq_r;
    end
  end

  // registered ack pulse and read data, forced to zero outside ACK
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_r <= 1'b0;
      dat_r <= DATA_ZERO;
    end else if (state_nxt_s == ACK) begin
      ack_r <= 1'b1;
      dat_r <= rd_data_s;
    end else begin
      ack_r <= 1'b0;
      dat_r <= DATA_ZERO;
    end
  end

  assign ack_o = ack_r;
  assign dat_o = dat_r;
  assign irq_o = irq_r;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) share clock, reset and
// bus signals; each has its own strobe so one is addressed at a time.
module tb_wb_slave_regfile;

  logic       clk;
  logic       rst;
  logic       cyc;
  logic [2:0] stb_v;
  logic       we;
  logic [1:0] adr;
  logic [7:0] dat;
  logic [7:0] dat_v [3];
  logic [2:0] ack_v;
  logic [2:0] irq_v;

  int n_vec  = 0;
  int n_miss = 0;

  wb_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .WAIT_STATES(1), .IRQ_ADDR(3)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb_v[0]), .we_i(we), .adr_i(adr),
    .dat_i(dat), .dat_o(dat_v[0]), .ack_o(ack_v[0]), .irq_o(irq_v[0]));

  wb_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .WAIT_STATES(0), .IRQ_ADDR(3)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb_v[1]), .we_i(we), .adr_i(adr),
    .dat_i(dat), .dat_o(dat_v[1]), .ack_o(ack_v[1]), .irq_o(irq_v[1]));

  wb_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .WAIT_STATES(3), .IRQ_ADDR(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb_v[2]), .we_i(we), .adr_i(adr),
    .dat_i(dat), .dat_o(dat_v[2]), .ack_o(ack_v[2]), .irq_o(irq_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one complete classic cycle; strobe held through the ack-ending edge
  task automatic wb_xfer(input int sel, input logic w, input logic [1:0] a,
                         input logic [7:0] d, input int ws, input logic [7:0] exp_rd);
    int lat;
    lat = 0;
    @(negedge clk);
    cyc = 1'b1; stb_v[sel] = 1'b1; we = w; adr = a; dat = d;
    for (int i = 1; i <= ws + 4; i++) begin
      @(negedge clk);
      if (ack_v[sel]) begin
        lat = i;
        break;
      end
      check_val("dat_before_ack", 32'(dat_v[sel]), 32'h0);
    end
    check_val("ack_latency", 32'(lat), 32'(ws + 1));
    if (!w) check_val("rd_data", 32'(dat_v[sel]), 32'(exp_rd));
    @(posedge clk); #1;
    cyc = 1'b0; stb_v[sel] = 1'b0;
    @(negedge clk);
    check_val("ack_single", 32'(ack_v[sel]), 32'h0);
    check_val("dat_after_ack", 32'(dat_v[sel]), 32'h0);
  endtask

  initial begin
    int acks;
    int pos1;
    int pos2;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;

    rst = 1'b0; cyc = 1'b0; stb_v = 3'b000; we = 1'b0; adr = 2'd0; dat = 8'h00;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_val("rst_ack", 32'(ack_v[s]), 32'h0);
      check_val("rst_dat", 32'(dat_v[s]), 32'h0);
      check_val("rst_irq", 32'(irq_v[s]), 32'h0);
    end
    rst = 1'b1;

    // 1: one wait state, write then read back
    wb_xfer(0, 1'b1, 2'd1, 8'h5A, 1, 8'h00);
    wb_xfer(0, 1'b0, 2'd1, 8'h00, 1, 8'h5A);

    // 2: zero wait states, fill and read back every register
    for (int i = 0; i < 4; i++) wb_xfer(1, 1'b1, 2'(i), exp_d[i], 0, 8'h00);
    for (int i = 0; i < 4; i++) wb_xfer(1, 1'b0, 2'(i), 8'h00, 0, exp_d[i]);

    // 3: interrupt follows bit 0 of register 3; reads leave it alone
    check_val("irq_before", 32'(irq_v[1]), 32'h0);
    wb_xfer(1, 1'b1, 2'd3, 8'h01, 0, 8'h00);
    check_val("irq_rise", 32'(irq_v[1]), 32'h1);
    wb_xfer(1, 1'b0, 2'd3, 8'h00, 0, 8'h01);
    check_val("irq_read_hold", 32'(irq_v[1]), 32'h1);
    wb_xfer(1, 1'b1, 2'd3, 8'hFE, 0, 8'h00);
    check_val("irq_fall", 32'(irq_v[1]), 32'h0);
    wb_xfer(1, 1'b1, 2'd3, 8'h01, 0, 8'h00);
    check_val("irq_rise2", 32'(irq_v[1]), 32'h1);

    // 4: three wait states, strobe dropped after one wait cycle
    @(negedge clk);
    cyc = 1'b1; stb_v[2] = 1'b1; we = 1'b1; adr = 2'd2; dat = 8'hA5;
    @(negedge clk);
    cyc = 1'b0; stb_v[2] = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack_v[2]) acks++;
    end
    check_val("abort_no_ack", 32'(acks), 32'h0);
    wb_xfer(2, 1'b0, 2'd2, 8'h00, 3, 8'h00);

    // 5: reset asserted while waiting
    @(negedge clk);
    cyc = 1'b1; stb_v[2] = 1'b1; we = 1'b1; adr = 2'd0; dat = 8'h77;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_mid_ack", 32'(ack_v[2]), 32'h0);
    check_val("rst_mid_dat", 32'(dat_v[2]), 32'h0);
    check_val("rst_mid_irq1", 32'(irq_v[1]), 32'h0);
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_v[2]) acks++;
    end
    cyc = 1'b0; stb_v[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_val("rst_mid_no_ack", 32'(acks), 32'h0);
    for (int i = 0; i < 4; i++) wb_xfer(1, 1'b0, 2'(i), 8'h00, 0, 8'h00);
    wb_xfer(2, 1'b0, 2'd0, 8'h00, 3, 8'h00);
    wb_xfer(0, 1'b0, 2'd1, 8'h00, 1, 8'h00);
    check_val("rst_irq_low", 32'(irq_v[1]), 32'h0);

    // 6a: strobe held into the IDLE cycle after ack, dropped before it is sampled
    @(negedge clk);
    cyc = 1'b1; stb_v[0] = 1'b1; we = 1'b1; adr = 2'd2; dat = 8'h3C;
    acks = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ack_v[0]) acks++;
      if (i == 3) begin
        cyc = 1'b0; stb_v[0] = 1'b0;
      end
    end
    check_val("hold_one_ack", 32'(acks), 32'h1);
    wb_xfer(0, 1'b0, 2'd2, 8'h00, 1, 8'h3C);

    // 6b: strobe held long enough for IDLE to accept a second request
    @(negedge clk);
    cyc = 1'b1; stb_v[0] = 1'b1; we = 1'b1; adr = 2'd2; dat = 8'h3D;
    acks = 0; pos1 = 0; pos2 = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (ack_v[0]) begin
        acks++;
        if (acks == 1) pos1 = i;
        if (acks == 2) pos2 = i;
      end
      if (i == 6) begin
        cyc = 1'b0; stb_v[0] = 1'b0;
      end
    end
    check_val("b2b_ack_count", 32'(acks), 32'h2);
    check_val("b2b_first_ack", 32'(pos1), 32'h2);
    check_val("b2b_second_ack", 32'(pos2), 32'h5);
    wb_xfer(0, 1'b0, 2'd2, 8'h00, 1, 8'h3D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
